vxe_mem_hub_m_us: RTL and testbench
===================================

Name: vxe_mem_hub_m_us

Overview:
- Master-port upstream arbiter in the memory hub; sits directly downstream of the per-client upstream routers.
- Pops requests from two client request FIFOs (CU0, CU1 routed traffic for one master port) and merges them into one master-port request FIFO.
- Round-robin arbitration with bounded burst length.
- Appends the source client id so the downstream response path can return data to the right client.

Parameters:
- DW, 44, request width (incoming rqa word).
- MAX_BURST, 4, max consecutive requests granted to one client while the other is waiting (legal 1..16).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_c0_rqa_vld  in  1  client 0 FIFO non-empty (show-ahead data valid)
- i_c0_rqa  in  DW  client 0 request word
- o_c0_rqa_rd  out  1  pop client 0 FIFO
- i_c1_rqa_vld  in  1  client 1 FIFO non-empty
- i_c1_rqa  in  DW  client 1 request word
- o_c1_rqa_rd  out  1  pop client 1 FIFO
- i_rqa_rdy  in  1  master FIFO not full
- o_rqa  out  DW+1  {client id, request}; bit DW = source client
- o_rqa_wr  out  1  write master FIFO

Behaviour:
- Reset: async on rst high. State=IDLE, burst count=0, rr pointer=0 (client 0 preferred first). o_c0_rqa_rd, o_c1_rqa_rd and o_rqa_wr are 0 while in reset. o_rqa may be don't-care but is driven 0 in IDLE.
- FSM states: IDLE, OWN0, OWN1.
- Owner dataflow is combinational pass-through, zero latency:
  - o_cX_rqa_rd = (state==OWNX) & i_cX_rqa_vld & i_rqa_rdy.
  - o_rqa_wr = OR of both rd.
  - o_rqa = {X, i_cX_rqa}.
  - At most one pop per cycle; never both rd high.
- IDLE:
  - No transfer.
  - Only one client valid -> that client's OWN next cycle.
  - Both valid -> client indicated by rr pointer.
  - Neither valid -> stay.
  - Arbitration latency from IDLE: 1 cycle.
- OWNX, transfer cycle (rd high):
  - Burst count increments.
  - If count reaches MAX_BURST-1 on this transfer and the other client is valid -> next state OWN(other), count=0, rr pointer=other. No bubble.
  - If count reaches MAX_BURST-1 and the other client is idle -> stay OWNX, count=0.
- OWNX, owner not valid:
  - Other valid -> OWN(other) next cycle, count=0. One bubble cycle.
  - Neither valid -> IDLE, count=0.
- i_rqa_rdy low: no pops, no writes; state, count and pointer hold. Ownership switch is not evaluated while stalled if the owner is valid.
- rdy low with owner empty and other valid: switch proceeds as above (no transfer lost).
- Burst count width: clog2(MAX_BURST), min 1 bit. MAX_BURST=1 gives strict alternation when both are valid.
- Reset mid-burst: immediate return to IDLE. Any request not yet popped stays in its client FIFO; nothing is duplicated or lost.

Optional Feature:
- Macro VXE_MEM_HUB_M_US_STATS_EN.
- When defined, adds three ports:
  - i_stat_clr  in  1
  - o_stat_c0  out  32
  - o_stat_c1  out  32
- Each counter increments on its client's o_cX_rqa_rd and saturates at 32'hFFFFFFFF.
- Counters reset to 0 on rst; synchronous clear on i_stat_clr.
- Clear has priority over increment in the same cycle.
- When not defined: ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Single client: c0 FIFO loaded with 8 words {6'b111100,1'b1,37'h0..7}, c1 empty, rdy=1 -> one IDLE cycle, then 8 back-to-back writes, o_rqa[44]=0, payload order 0..7.
- Contention: both FIFOs continuously valid, MAX_BURST=4 -> write sequence c0,c0,c0,c0,c1,c1,c1,c1,c0..., no bubble at switch, first owner c0 after reset.
- Backpressure: i_rqa_rdy low for 3 cycles after the 2nd c0 write -> no rd/wr for 3 cycles; after release, exactly 2 more c0 writes, then switch to c1.
- Owner drains: c0 holds 2 words, c1 holds 5 -> 2 c0 writes, 1 bubble cycle, 5 c1 writes (o_rqa[44]=1), then IDLE.
- Reset mid-burst: rst pulsed after 2nd c1 write of a burst -> rd/wr drop immediately; after release, first grant goes to c0 if both valid, remaining c1 words delivered intact.
- Stats (macro on): 10 c0 and 6 c1 transfers -> o_stat_c0=10, o_stat_c1=6; i_stat_clr concurrent with a c0 pop -> o_stat_c0=0 next cycle.

Source files
------------

// File: rtl/vxe_mem_hub_m_us.sv
// -----------------------------------------------------------------------------
// vxe_mem_hub_m_us
// Master-port upstream arbiter. Merges the two client request FIFOs (CU0/CU1
// traffic routed to this master port) into the single master-port request
// FIFO. Round-robin between clients with a bounded burst length, and the
// source client id is appended as the MSB of each forwarded word so the
// response path can route data back.
//
// Parameters
//   DW         request word width
//   MAX_BURST  max consecutive grants to one client while the other waits
//              (legal 1..16; 1 gives strict alternation under contention)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   i_cX_rqa_vld / i_cX_rqa   client X FIFO show-ahead valid / data
//   o_cX_rqa_rd               pop client X FIFO
//   i_rqa_rdy                 master FIFO not full
//   o_rqa                     {source client, request word}
//   o_rqa_wr                  write master FIFO
//
// Optional: define VXE_MEM_HUB_M_US_STATS_EN to add per-client transfer
// counters (i_stat_clr, o_stat_c0, o_stat_c1). Arbitration is unaffected.
// -----------------------------------------------------------------------------
module vxe_mem_hub_m_us #(
   parameter int DW        = 44,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_c0_rqa_vld,
   input  logic [DW-1:0] i_c0_rqa,
   output logic          o_c0_rqa_rd,
   input  logic          i_c1_rqa_vld,
   input  logic [DW-1:0] i_c1_rqa,
   output logic          o_c1_rqa_rd,
   input  logic          i_rqa_rdy,
   output logic [DW:0]   o_rqa,
   output logic          o_rqa_wr
`ifdef VXE_MEM_HUB_M_US_STATS_EN
   ,
   input  logic          i_stat_clr,
   output logic [31:0]   o_stat_c0,
   output logic [31:0]   o_stat_c1
`endif
);

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          rr, rr_nxt;     // preferred client when both request from IDLE

   logic          own_vld, oth_vld;
   logic          burst_end;

   // ---------------------------------------------------------------------------
   // Datapath: owner passes straight through, zero latency.
   // ---------------------------------------------------------------------------
   assign o_c0_rqa_rd = (state == OWN0) && i_c0_rqa_vld && i_rqa_rdy;
   assign o_c1_rqa_rd = (state == OWN1) && i_c1_rqa_vld && i_rqa_rdy;
   assign o_rqa_wr    = o_c0_rqa_rd || o_c1_rqa_rd;

   always_comb begin
      o_rqa = '0;
      case (state)
         OWN0:    o_rqa = {1'b0, i_c0_rqa};
         OWN1:    o_rqa = {1'b1, i_c1_rqa};
         default: o_rqa = '0;
      endcase
   end

   assign own_vld   = (state == OWN1) ? i_c1_rqa_vld : i_c0_rqa_vld;
   assign oth_vld   = (state == OWN1) ? i_c0_rqa_vld : i_c1_rqa_vld;
   assign burst_end = (cnt == BURST_LAST);

   // ---------------------------------------------------------------------------
   // Arbitration FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rr    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rr    <= rr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rr_nxt    = rr;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (i_c0_rqa_vld && i_c1_rqa_vld)
               state_nxt = rr ? OWN1 : OWN0;
            else if (i_c0_rqa_vld)
               state_nxt = OWN0;
            else if (i_c1_rqa_vld)
               state_nxt = OWN1;
         end
         OWN0, OWN1: begin
            if (own_vld) begin
               // Owner has data: only a real transfer advances the burst.
               // A stalled owner holds everything, including ownership.
               if (i_rqa_rdy) begin
                  if (burst_end) begin
                     cnt_nxt = '0;
                     if (oth_vld) begin
                        state_nxt = (state == OWN0) ? OWN1 : OWN0;
                        rr_nxt    = (state == OWN0);
                     end
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end
            end else begin
               // Owner drained: hand over (one bubble) or go idle, rdy or not.
               cnt_nxt   = '0;
               if (oth_vld)
                  state_nxt = (state == OWN0) ? OWN1 : OWN0;
               else
                  state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

`ifdef VXE_MEM_HUB_M_US_STATS_EN
   // ---------------------------------------------------------------------------
   // Per-client transfer counters, saturating; clear wins over increment.
   // ---------------------------------------------------------------------------
   logic [1:0]        stat_inc;
   logic [1:0][31:0]  stat_cnt;

   assign stat_inc = {o_c1_rqa_rd, o_c0_rqa_rd};

   for (genvar g = 0; g < 2; g++) begin : g_stat
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            stat_cnt[g] <= '0;
         else if (i_stat_clr)
            stat_cnt[g] <= '0;
         else if (stat_inc[g] && (stat_cnt[g] != 32'hFFFF_FFFF))
            stat_cnt[g] <= stat_cnt[g] + 32'd1;
      end
   end

   assign o_stat_c0 = stat_cnt[0];
   assign o_stat_c1 = stat_cnt[1];
`endif

endmodule

// File: tb/tb_vxe_mem_hub_m_us.sv
// Scoreboard bench for vxe_mem_hub_m_us (DW=44, MAX_BURST=4). Client FIFOs are
// modelled as queues; stimulus pushes expected master-FIFO words (with the
// expected cycle gap to the previous write, -1 = don't care) into exp_q and a
// negedge monitor pops and compares on every o_rqa_wr.
module tb_vxe_mem_hub_m_us;
   localparam int DW = 44;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          c0_vld = 1'b0, c1_vld = 1'b0;
   logic [DW-1:0] c0_dat = '0, c1_dat = '0;
   logic          c0_rd, c1_rd;
   logic          rdy = 1'b1;
   logic [DW:0]   rqa;
   logic          wr;
`ifdef VXE_MEM_HUB_M_US_STATS_EN
   logic          stat_clr = 1'b0;
   logic [31:0]   stat_c0, stat_c1;
`endif

   vxe_mem_hub_m_us #(.DW(DW), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .i_c0_rqa_vld(c0_vld), .i_c0_rqa(c0_dat), .o_c0_rqa_rd(c0_rd),
      .i_c1_rqa_vld(c1_vld), .i_c1_rqa(c1_dat), .o_c1_rqa_rd(c1_rd),
      .i_rqa_rdy(rdy), .o_rqa(rqa), .o_rqa_wr(wr)
`ifdef VXE_MEM_HUB_M_US_STATS_EN
      , .i_stat_clr(stat_clr), .o_stat_c0(stat_c0), .o_stat_c1(stat_c1)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW:0] w;
      int          gap;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] c0_q[$], c1_q[$];
   int            n_chk = 0, n_fail = 0;
   int            cyc = 0, last_wr = 0, wr_cnt = 0;
   logic          p0 = 1'b0, p1 = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [7:0] tag, input int i);
      return {4'h0, tag, 32'(i)};
   endfunction

   task automatic ex(input logic src, input logic [DW-1:0] w, input int gap);
      exp_t e;
      e.w   = {src, w};
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Client FIFO model: pop on the posedge that completed a transfer, then
   // present the new head 1 time unit later.
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (p0 && c0_q.size() > 0) c0_q.delete(0);
      if (p1 && c1_q.size() > 0) c1_q.delete(0);
      c0_vld = (c0_q.size() > 0);
      c0_dat = (c0_q.size() > 0) ? c0_q[0] : '0;
      c1_vld = (c1_q.size() > 0);
      c1_dat = (c1_q.size() > 0) ? c1_q[0] : '0;
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      p0 = c0_rd;
      p1 = c1_rd;
      if (p0 && p1) chk("both_rd", 1, 0);
      if (wr) begin
         chk("wr_eq_rd", {63'd0, wr}, {63'd0, p0 | p1});
         if (exp_q.size() == 0) begin
            chk("unexpected_wr", {19'd0, rqa}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rqa_data", {19'd0, rqa}, {19'd0, e.w});
            if (e.gap >= 0) chk("wr_gap", 64'(cyc - last_wr), 64'(e.gap));
         end
         last_wr = cyc;
         wr_cnt++;
      end
   end

   task automatic chk_quiet(input string nm);
      chk(nm, {61'd0, wr, c0_rd, c1_rd}, 64'd0);
   endtask

   // Called aligned at posedge+2; returns aligned at posedge+2.
   task automatic reset_dut();
      @(posedge clk); #2;
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk_quiet("reset_outputs");
      end
      chk("reset_rqa", {19'd0, rqa}, 64'd0);
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0 && c0_q.size() == 0 && c1_q.size() == 0) break;
      end
      chk({nm, "_drained"}, 64'(exp_q.size() + c0_q.size() + c1_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      chk_quiet({nm, "_idle_after"});
   endtask

   task automatic wait_wr(input int target, input string nm);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #1;
         if (wr_cnt >= target) break;
      end
      chk(nm, {63'd0, wr_cnt >= target}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      // Reset state
      repeat (2) @(negedge clk);
      chk_quiet("por_outputs");
      chk("por_rqa", {19'd0, rqa}, 64'd0);
      @(posedge clk); #2;
      rst = 1'b0;

      // T1: single client, 8 words, one IDLE cycle then back-to-back
      for (int i = 0; i < 8; i++) begin
         c0_q.push_back({6'b111100, 1'b1, 37'(i)});
         ex(1'b0, {6'b111100, 1'b1, 37'(i)}, (i == 0) ? -1 : 1);
      end
      @(negedge clk);
      @(negedge clk); chk("t1_idle_cycle", {63'd0, wr}, 64'd0);
      @(negedge clk); chk("t1_first_wr", {63'd0, wr}, 64'd1);
      drain("t1");

      // T2: contention, bursts of 4 alternating, c0 first, no bubbles
      reset_dut();
      for (int i = 0; i < 12; i++) begin
         c0_q.push_back(mk(8'hA2, i));
         c1_q.push_back(mk(8'hB2, i));
      end
      for (int b = 0; b < 6; b++)
         for (int j = 0; j < 4; j++)
            ex(b[0], b[0] ? mk(8'hB2, (b / 2) * 4 + j) : mk(8'hA2, (b / 2) * 4 + j),
               (b == 0 && j == 0) ? -1 : 1);
      drain("t2");

      // T3: backpressure for 3 cycles after the 2nd c0 write
      reset_dut();
      base = wr_cnt;
      for (int i = 0; i < 6; i++) c0_q.push_back(mk(8'hA3, i));
      for (int i = 0; i < 4; i++) c1_q.push_back(mk(8'hB3, i));
      ex(1'b0, mk(8'hA3, 0), -1);
      ex(1'b0, mk(8'hA3, 1), 1);
      ex(1'b0, mk(8'hA3, 2), 4);
      ex(1'b0, mk(8'hA3, 3), 1);
      for (int i = 0; i < 4; i++) ex(1'b1, mk(8'hB3, i), 1);
      ex(1'b0, mk(8'hA3, 4), 1);
      ex(1'b0, mk(8'hA3, 5), 1);
      wait_wr(base + 2, "t3_reach_2nd_wr");
      @(posedge clk); #2;
      rdy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_quiet("t3_stall_quiet");
      end
      @(posedge clk); #2;
      rdy = 1'b1;
      drain("t3");

      // T4: owner drains -> one bubble -> other client, then IDLE
      reset_dut();
      for (int i = 0; i < 2; i++) c0_q.push_back(mk(8'hA4, i));
      for (int i = 0; i < 5; i++) c1_q.push_back(mk(8'hB4, i));
      ex(1'b0, mk(8'hA4, 0), -1);
      ex(1'b0, mk(8'hA4, 1), 1);
      ex(1'b1, mk(8'hB4, 0), 2);
      for (int i = 1; i < 5; i++) ex(1'b1, mk(8'hB4, i), 1);
      drain("t4");

      // T5: reset mid-burst of c1; nothing lost, c0 wins after reset
      reset_dut();
      base = wr_cnt;
      for (int i = 0; i < 6; i++) c1_q.push_back(mk(8'hB5, i));
      ex(1'b1, mk(8'hB5, 0), -1);
      ex(1'b1, mk(8'hB5, 1), 1);
      wait_wr(base + 2, "t5_reach_2nd_wr");
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk);
      chk_quiet("t5_reset_drop");
      for (int i = 0; i < 3; i++) c0_q.push_back(mk(8'hA5, i));
      ex(1'b0, mk(8'hA5, 0), -1);
      ex(1'b0, mk(8'hA5, 1), 1);
      ex(1'b0, mk(8'hA5, 2), 1);
      ex(1'b1, mk(8'hB5, 2), 2);
      for (int i = 3; i < 6; i++) ex(1'b1, mk(8'hB5, i), 1);
      @(posedge clk); #2;
      rst = 1'b0;
      drain("t5");

`ifdef VXE_MEM_HUB_M_US_STATS_EN
      // T6: statistics counters
      reset_dut();
      for (int i = 0; i < 10; i++) c0_q.push_back(mk(8'hA6, i));
      for (int i = 0; i < 6; i++)  c1_q.push_back(mk(8'hB6, i));
      for (int i = 0; i < 4; i++)  ex(1'b0, mk(8'hA6, i), (i == 0) ? -1 : 1);
      for (int i = 0; i < 4; i++)  ex(1'b1, mk(8'hB6, i), 1);
      for (int i = 4; i < 8; i++)  ex(1'b0, mk(8'hA6, i), 1);
      ex(1'b1, mk(8'hB6, 4), 1);
      ex(1'b1, mk(8'hB6, 5), 1);
      ex(1'b0, mk(8'hA6, 8), 2);
      ex(1'b0, mk(8'hA6, 9), 1);
      drain("t6");
      chk("stat_c0", 64'(stat_c0), 64'd10);
      chk("stat_c1", 64'(stat_c1), 64'd6);
      @(posedge clk); #2;
      base = wr_cnt;
      for (int i = 0; i < 3; i++) begin
         c0_q.push_back(mk(8'hA7, i));
         ex(1'b0, mk(8'hA7, i), (i == 0) ? -1 : 1);
      end
      wait_wr(base + 1, "t7_first_wr");
      stat_clr = 1'b1;
      @(posedge clk); #2;
      stat_clr = 1'b0;
      @(negedge clk);
      chk("stat_clr_wins", 64'(stat_c0), 64'd0);
      drain("t7");
      chk("stat_c0_after_clr", 64'(stat_c0), 64'd2);
      chk("stat_c1_after_clr", 64'(stat_c1), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
